// File: rtl/y_operand_stage.sv
// y_operand_stage: decode-to-execute operand stage.
// Holds the general-purpose register file (two combinational read ports, one
// write-back port) and the ID/EX pipeline register that feeds the ALU.
// Optional feature macro: OPERAND_WB_BYPASS_EN. When it is defined, a write-back
// to a non-zero register is forwarded to a matching read port in the same cycle.
// When it is undefined, reads return the pre-write contents.
module y_operand_stage #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [AW-1:0]     rs,
  input  logic [AW-1:0]     rt,
  input  logic [15:0]       imm,
  input  logic              use_imm,
  input  logic [2:0]        op_in,
  input  logic [AW-1:0]     wdst_in,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [2:0]        op,
  output logic [DATA_W-1:0] rt_data,
  output logic [AW-1:0]     wdst
);

  localparam int IMM_W = 16;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_sext;
  logic              wb_commit;

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] a_q,       a_d;
  logic [DATA_W-1:0] b_q,       b_d;
  logic [2:0]        op_q,      op_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [AW-1:0]     wdst_q,    wdst_d;

  // R0 is hardwired to zero, so writes addressed to it never commit.
  assign wb_commit = wb_en && (wb_addr != '0);

  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  // Register file: write-back is independent of stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_commit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Read ports: R0 reads zero and is never forwarded.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != '0) begin
`ifdef OPERAND_WB_BYPASS_EN
      rs_val = (wb_commit && (wb_addr == rs)) ? wb_data : regs_q[rs];
`else
      rs_val = regs_q[rs];
`endif
    end
    if (rt != '0) begin
`ifdef OPERAND_WB_BYPASS_EN
      rt_val = (wb_commit && (wb_addr == rt)) ? wb_data : regs_q[rt];
`else
      rt_val = regs_q[rt];
`endif
    end
  end

  // ID/EX next state: flush clears only the valid bit, stall holds everything.
  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rt_data_d = rt_data_q;
    wdst_d    = wdst_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d   = in_valid;
      a_d       = rs_val;
      b_d       = use_imm ? imm_sext : rt_val;
      op_d      = op_in;
      rt_data_d = rt_val;
      wdst_d    = wdst_in;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rt_data_q <= '0;
      wdst_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rt_data_q <= rt_data_d;
      wdst_q    <= wdst_d;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign rt_data   = rt_data_q;
  assign wdst      = wdst_q;

endmodule

// File: tb/tb_y_operand_stage.sv
// Directed bench for y_operand_stage: a vector table for the single-cycle
// behaviour plus hand-written stall, flush and reset sequences.
module tb_y_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, use_imm, wb_en;
  logic [4:0]  rs, rt, wdst_in, wb_addr;
  logic [15:0] imm;
  logic [2:0]  op_in;
  logic [31:0] wb_data;
  logic        in_ready, out_valid;
  logic [31:0] a, b, rt_data;
  logic [2:0]  op;
  logic [4:0]  wdst;

  int checks   = 0;
  int failures = 0;

`ifdef OPERAND_WB_BYPASS_EN
  localparam logic [31:0] BYP_A = 32'h1234_5678;
`else
  localparam logic [31:0] BYP_A = 32'h0000_0000;
`endif

  typedef struct {
    logic        in_valid, stall, flush;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        use_imm;
    logic [2:0]  op_in;
    logic [4:0]  wdst_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        e_ov;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_op;
    logic [31:0] e_rt;
    logic [4:0]  e_wdst;
  } vec_t;

  y_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs(rs), .rt(rt), .imm(imm), .use_imm(use_imm), .op_in(op_in),
    .wdst_in(wdst_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .in_ready(in_ready), .out_valid(out_valid), .a(a), .b(b), .op(op),
    .rt_data(rt_data), .wdst(wdst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.in_valid; stall = v.stall; flush = v.flush;
    rs = v.rs; rt = v.rt; imm = v.imm; use_imm = v.use_imm;
    op_in = v.op_in; wdst_in = v.wdst_in;
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v.e_ov});
    check({tag, ".a"},         a,                  v.e_a);
    check({tag, ".b"},         b,                  v.e_b);
    check({tag, ".op"},        {29'd0, op},        {29'd0, v.e_op});
    check({tag, ".rt_data"},   rt_data,            v.e_rt);
    check({tag, ".wdst"},      {27'd0, wdst},      {27'd0, v.e_wdst});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    step();
    check_out(tag, v);
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'h0,
          1'b0, 32'h0, 32'h0, 3'd0, 32'h0, 5'd0};
    check_out(tag, z);
  endtask

  task automatic scan_zero(input string tag);
    vec_t v;
    for (int i = 1; i < 32; i++) begin
      v = '{1'b1, 1'b0, 1'b0, 5'(i), 5'(i), 16'h0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'h0,
            1'b1, 32'h0, 32'h0, 3'd0, 32'h0, 5'd0};
      drive(v);
      step();
      check({tag, ".a"},       a,       32'h0);
      check({tag, ".rt_data"}, rt_data, 32'h0);
    end
  endtask

  vec_t tbl [8];
  vec_t v;

  initial begin
    // in_valid stall flush rs rt imm use_imm op wdst wb_en wb_addr wb_data | ov a b op rt wdst
    tbl[0] = '{0,0,0, 5'd0, 5'd0, 16'h0000, 0, 3'd0, 5'd0,  1, 5'd5, 32'hDEAD_BEEF,
               0, 32'h0, 32'h0, 3'd0, 32'h0, 5'd0};
    tbl[1] = '{1,0,0, 5'd5, 5'd5, 16'h0000, 0, 3'd1, 5'd3,  0, 5'd0, 32'h0,
               1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd1, 32'hDEAD_BEEF, 5'd3};
    tbl[2] = '{1,0,0, 5'd7, 5'd5, 16'h0010, 1, 3'd2, 5'd4,  1, 5'd7, 32'h1234_5678,
               1, BYP_A, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 5'd4};
    tbl[3] = '{1,0,0, 5'd7, 5'd7, 16'h0000, 0, 3'd3, 5'd7,  0, 5'd0, 32'h0,
               1, 32'h1234_5678, 32'h1234_5678, 3'd3, 32'h1234_5678, 5'd7};
    tbl[4] = '{1,0,0, 5'd0, 5'd5, 16'hFFFC, 1, 3'd4, 5'd1,  1, 5'd0, 32'hFFFF_FFFF,
               1, 32'h0, 32'hFFFF_FFFC, 3'd4, 32'hDEAD_BEEF, 5'd1};
    tbl[5] = '{0,0,0, 5'd0, 5'd0, 16'h0000, 0, 3'd5, 5'd0,  0, 5'd0, 32'h0,
               0, 32'h0, 32'h0, 3'd5, 32'h0, 5'd0};
    tbl[6] = '{1,0,0, 5'd5, 5'd7, 16'h7FFF, 1, 3'd6, 5'd31, 0, 5'd0, 32'h0,
               1, 32'hDEAD_BEEF, 32'h0000_7FFF, 3'd6, 32'h1234_5678, 5'd31};
    tbl[7] = '{1,0,1, 5'd7, 5'd0, 16'h0001, 0, 3'd7, 5'd2,  0, 5'd0, 32'h0,
               0, 32'hDEAD_BEEF, 32'h0000_7FFF, 3'd6, 32'h1234_5678, 5'd31};

    // Reset with arbitrary inputs: outputs zero immediately, in_ready tracks stall.
    rst = 1'b1;
    drive('{1,1,0, 5'd3, 5'd4, 16'hABCD, 1, 3'd5, 5'd6, 1, 5'd9, 32'h5555_AAAA,
            0, 32'h0, 32'h0, 3'd0, 32'h0, 5'd0});
    #2;
    check_zero("reset_async");
    check("reset.in_ready_stalled", {31'd0, in_ready}, 32'd0);
    stall = 1'b0;
    #1;
    check("reset.in_ready_free", {31'd0, in_ready}, 32'd1);
    step();
    check_zero("reset_held");
    rst = 1'b0;
    scan_zero("reset_scan");

    for (int i = 0; i < 8; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Stall: issue, then hold 3 cycles while inputs change.
    v = '{1,0,0, 5'd5, 5'd7, 16'h0000, 0, 3'b010, 5'd2, 0, 5'd0, 32'h0,
          1, 32'hDEAD_BEEF, 32'h1234_5678, 3'b010, 32'h1234_5678, 5'd2};
    apply("stall_issue", v);
    for (int i = 0; i < 3; i++) begin
      v.in_valid = 1'b0; v.stall = 1'b1; v.rs = 5'd7; v.rt = 5'd0;
      v.op_in = 3'd7; v.wdst_in = 5'd9; v.use_imm = 1'b1; v.imm = 16'h8000;
      drive(v);
      #1;
      check($sformatf("stall%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      step();
      check_out($sformatf("stall%0d", i), v);
    end
    v.stall = 1'b0;
    v.e_ov = 1'b0; v.e_a = 32'h1234_5678; v.e_b = 32'hFFFF_8000;
    v.e_op = 3'd7; v.e_rt = 32'h0; v.e_wdst = 5'd9;
    apply("stall_release", v);

    // Flush beats stall; a write-back in that cycle still commits.
    v = '{1,0,0, 5'd5, 5'd5, 16'h0000, 0, 3'd1, 5'd1, 0, 5'd0, 32'h0,
          1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd1, 32'hDEAD_BEEF, 5'd1};
    apply("flush_issue", v);
    v = '{1,1,1, 5'd9, 5'd9, 16'h0000, 0, 3'd4, 5'd8, 1, 5'd9, 32'hCAFE_F00D,
          0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd1, 32'hDEAD_BEEF, 5'd1};
    apply("flush_stall", v);
    v = '{1,0,0, 5'd9, 5'd9, 16'h0000, 0, 3'd4, 5'd8, 0, 5'd0, 32'h0,
          1, 32'hCAFE_F00D, 32'hCAFE_F00D, 3'd4, 32'hCAFE_F00D, 5'd8};
    apply("flush_wb_read", v);

    // Reset mid-operation with a pending write: outputs clear at once, write lost.
    drive('{1,0,0, 5'd5, 5'd7, 16'h0000, 0, 3'd3, 5'd3, 1, 5'd11, 32'h0BAD_0BAD,
            0, 32'h0, 32'h0, 3'd0, 32'h0, 5'd0});
    rst = 1'b1;
    #1;
    check_zero("midreset_async");
    step();
    rst = 1'b0;
    wb_en = 1'b0;
    #1;
    check_zero("midreset_released");
    scan_zero("midreset_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
